// File: rtl/pipe_result_collector.sv
// Result collector for the free-running 3-stage arithmetic pipeline: tags real issues,
// captures their results into a fall-through FIFO and throttles issue with credits.
module pipe_result_collector #(
    parameter int N     = 10,
    parameter int LAT   = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [N-1:0]             pipe_f,
    output logic                     out_valid,
    output logic [N-1:0]             out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = AW + 2;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [LAT-1:0] r_vld;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW-1:0]  r_wr_ptr;
    logic [CW-1:0]  r_count;
    logic           r_err;
    logic [N-1:0]   r_mem [DEPTH];

    logic           w_fire;
    logic           w_write;
    logic           w_pop;
    logic [SW-1:0]  w_inflight;
    logic [SW-1:0]  w_credit_sum;

    // Credits count both buffered results and results still inside the pipeline,
    // so every tagged issue already owns a FIFO slot when its result arrives.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            w_inflight = w_inflight + SW'(r_vld[i]);
        end
        w_credit_sum = SW'(r_count) + w_inflight;
    end

    assign issue_ready = (w_credit_sum < SW'(DEPTH));
    assign w_fire      = issue_valid & issue_ready;
    assign w_write     = r_vld[LAT-1];
    assign out_valid   = (r_count != '0);
    assign w_pop       = out_valid & out_ready;
    assign out_data    = out_valid ? r_mem[r_rd_ptr] : '0;
    assign count       = r_count;
    assign err         = r_err;

    generate
        if (LAT == 1) begin : g_vld_single
            always_ff @(posedge clk) begin
                if (!rst_n) r_vld <= '0;
                else        r_vld <= w_fire;
            end
        end else begin : g_vld_shift
            always_ff @(posedge clk) begin
                if (!rst_n) r_vld <= '0;
                else        r_vld <= {r_vld[LAT-2:0], w_fire};
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_write) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (issue_valid && !issue_ready) r_err <= 1'b1;
        end
    end

    // Storage is deliberately not reset; the pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (rst_n && w_write) r_mem[r_wr_ptr] <= pipe_f;
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) assert (!(w_write && !w_pop && r_count == FULL));
    end
`endif

endmodule

// File: tb/tb_pipe_result_collector.sv
// Directed bench for pipe_result_collector with a behavioural model of the
// (a+b+c-d)*d three-stage pipeline feeding pipe_f.
module tb_pipe_result_collector;

    localparam int N     = 10;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          issue_valid;
    logic          issue_ready;
    logic [N-1:0]  pipe_f;
    logic          out_valid;
    logic [N-1:0]  out_data;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          err;

    logic [N-1:0]  op_a, op_b, op_c, op_d;
    int            s1_sum = 0;
    int            s1_d   = 0;
    int            s2     = 0;
    int            s3     = 0;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [N-1:0]  exp_q[$];

    always #5 clk = ~clk;

    pipe_result_collector #(.N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .pipe_f      (pipe_f),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .count       (count),
        .err         (err)
    );

    // Operands captured at edge k give a result sampleable at edge k+3.
    always @(posedge clk) begin
        s1_sum <= int'(op_a) + int'(op_b) + int'(op_c) - int'(op_d);
        s1_d   <= int'(op_d);
        s2     <= s1_sum * s1_d;
        s3     <= s2;
    end
    assign pipe_f = N'(s3);

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard: every accepted head must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check_val("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check_val("sb_order", out_data, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_garbage();
        op_a = 10'd1000; op_b = 10'd0; op_c = 10'd0; op_d = 10'd1;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        set_garbage();
        tick();
    endtask

    task automatic issue(input int a, input int b, input int c, input int d, input int exp);
        check_val("issue_ready_before_fire", issue_ready, 1);
        issue_valid = 1'b1;
        op_a = N'(a); op_b = N'(b); op_c = N'(c); op_d = N'(d);
        exp_q.push_back(N'(exp));
        tick();
        issue_valid = 1'b0;
        set_garbage();
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) tick();
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        out_ready   = 1'b0;
        set_garbage();

        // Reset state
        do_reset(2);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_count", count, 0);
        check_val("rst_issue_ready", issue_ready, 1);
        check_val("rst_err", err, 0);

        // Single issue, captured three edges later, no bypass
        issue(10, 12, 6, 2, 52);
        idle();
        idle();
        check_val("single_not_yet", out_valid, 0);
        idle();
        check_val("single_valid", out_valid, 1);
        check_val("single_data", out_data, 52);
        check_val("single_count", count, 1);
        out_ready = 1'b1;
        idle();
        check_val("single_drained", count, 0);

        // Back-to-back stream with out_ready held high
        issue(10, 12, 6, 2, 52);
        issue(10, 10, 5, 3, 66);
        issue(20, 11, 1, 4, 112);
        issue(12, 15, 4, 2, 58);
        check_val("stream_0", out_data, 52);
        idle();
        check_val("stream_1", out_data, 66);
        idle();
        check_val("stream_2", out_data, 112);
        idle();
        check_val("stream_3", out_data, 58);
        idle();
        check_val("stream_done_valid", out_valid, 0);
        check_val("stream_done_count", count, 0);

        // Backpressure: credits run out after four fires
        out_ready = 1'b0;
        issue(1, 2, 3, 4, 8);
        issue(5, 6, 7, 3, 45);
        issue(150, 100, 50, 3, 891);
        issue(7, 0, 0, 7, 0);
        check_val("bp_ready_low", issue_ready, 0);
        check_val("bp_count1", count, 1);
        idle();
        check_val("bp_count2", count, 2);
        idle();
        check_val("bp_count3", count, 3);
        check_val("bp_ready_low3", issue_ready, 0);
        idle();
        check_val("bp_count4", count, 4);
        check_val("bp_ready_full", issue_ready, 0);
        check_val("bp_err", err, 0);

        // One pop frees a credit, then a capture coincides with a pop
        out_ready = 1'b1;
        idle();
        check_val("pop_count3", count, 3);
        check_val("pop_ready", issue_ready, 1);
        out_ready = 1'b0;
        issue(10, 12, 6, 2, 52);
        check_val("credit_ready_low", issue_ready, 0);
        idle();
        idle();
        check_val("pre_simul_count", count, 3);
        out_ready = 1'b1;
        idle();
        check_val("simul_count", count, 3);
        check_val("simul_head", out_data, 891);
        idle();
        idle();
        idle();
        check_val("simul_drained", count, 0);
        check_val("simul_err", err, 0);

        // Protocol violation: issue while not ready is not tracked and sets err
        out_ready = 1'b0;
        issue(10, 12, 6, 2, 52);
        issue(10, 10, 5, 3, 66);
        issue(20, 11, 1, 4, 112);
        issue(12, 15, 4, 2, 58);
        check_val("viol_ready_low", issue_ready, 0);
        issue_valid = 1'b1;
        op_a = 10'd1; op_b = 10'd2; op_c = 10'd3; op_d = 10'd4;
        tick();
        check_val("viol_err_set", err, 1);
        idle();
        idle();
        idle();
        check_val("viol_not_tracked", count, 4);
        out_ready = 1'b1;
        repeat (4) idle();
        check_val("viol_drained", count, 0);
        idle();
        check_val("viol_no_extra", out_valid, 0);
        check_val("viol_err_sticky", err, 1);
        check_val("viol_sb_empty", exp_q.size(), 0);

        // Reset mid-flight discards in-flight results and clears err
        do_reset(1);
        check_val("rst2_err", err, 0);
        out_ready = 1'b0;
        issue(10, 12, 6, 2, 52);
        issue(10, 10, 5, 3, 66);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            idle();
            check_val("midrst_valid", out_valid, 0);
            check_val("midrst_count", count, 0);
        end
        check_val("midrst_ready", issue_ready, 1);

        check_val("final_sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
